cmd_arbiter: RTL

Round-robin arbiter sharing the single system-clock register command bus among `NUM_REQ` command masters, e.g. the MIB slave path and the UDP command path. Each master holds a request until it is acknowledged. The arbiter issues one command downstream at a time, waits for the register block's acknowledge or a timeout, and returns the read data and an error flag to the granted master. It sits in the `o_sys_clk` domain between the command sources and the register PIO block.

---
 rtl/cmd_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter issuing one register command at a time with ack timeout
module cmd_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 32,
   parameter int ACK_TIMEOUT_CLKS = 256,
   parameter logic [DATA_BITS-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           i_sys_clk,
   input  logic                           i_sys_srst,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   input  logic [NUM_REQ-1:0]             i_req_wr_en,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_wdata,
   output logic [NUM_REQ-1:0]             o_req_ack,
   output logic                           o_req_err,
   output logic [DATA_BITS-1:0]           o_req_rdata,
   output logic                           o_cmd_valid,
   output logic                           o_cmd_wr_en,
   output logic [ADDR_BITS-1:0]           o_cmd_addr,
   output logic [DATA_BITS-1:0]           o_cmd_wdata,
   input  logic                           i_cmd_ack,
   input  logic [DATA_BITS-1:0]           i_cmd_rdata,
   output logic                           o_busy,
   output logic [GW-1:0]                  o_grant_idx,
   output logic [7:0]                     o_timeout_cnt
);
   localparam int CW = $clog2(ACK_TIMEOUT_CLKS + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [GW-1:0] win;
   logic win_ok, take_ack, take_to;
   // descending scan so the nearest requester after the last grant is assigned last
   always_comb begin
      win = o_grant_idx;
      win_ok = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (i_req_valid[GW'((int'(o_grant_idx) + i) % NUM_REQ)]) begin
            win = GW'((int'(o_grant_idx) + i) % NUM_REQ);
            win_ok = 1'b1;
         end
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      take_ack = 1'b0;
      take_to = 1'b0;
      case (state)
         IDLE: state_nxt = win_ok ? ISSUE : IDLE;
         ISSUE: begin
            cnt_nxt = CW'(1);
            take_ack = i_cmd_ack;
            state_nxt = i_cmd_ack ? RESP : WAIT;
         end
         WAIT: begin
            cnt_nxt = cnt + CW'(1);
            take_ack = i_cmd_ack;
            take_to = !i_cmd_ack && (cnt_nxt == CW'(ACK_TIMEOUT_CLKS));
            state_nxt = (take_ack || take_to) ? RESP : WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_srst) begin
         state <= IDLE;
         cnt <= '0;
         o_grant_idx <= GW'(NUM_REQ - 1);
         o_cmd_wr_en <= 1'b0;
         o_cmd_addr <= '0;
         o_cmd_wdata <= '0;
         o_req_ack <= '0;
         o_req_err <= 1'b0;
         o_req_rdata <= '0;
         o_cmd_valid <= 1'b0;
         o_busy <= 1'b0;
         o_timeout_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         if (state == IDLE && win_ok) begin
            o_grant_idx <= win;
            o_cmd_wr_en <= i_req_wr_en[win];
            o_cmd_addr <= i_req_addr[win*ADDR_BITS +: ADDR_BITS];
            o_cmd_wdata <= i_req_wdata[win*DATA_BITS +: DATA_BITS];
         end
         if (take_ack) begin
            o_req_rdata <= i_cmd_rdata;
            o_req_err <= 1'b0;
         end
         if (take_to) begin
            o_req_rdata <= TIMEOUT_DATA;
            o_req_err <= 1'b1;
            if (o_timeout_cnt != 8'hFF) o_timeout_cnt <= o_timeout_cnt + 8'd1;
         end
         // outputs are registered from the next state so they align with it
         o_cmd_valid <= (state_nxt == ISSUE);
         o_busy <= (state_nxt != IDLE);
         o_req_ack <= (state_nxt == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_grant_idx) : '0;
      end
   end
endmodule
